// File: rtl/trackball_pkg.sv
// Shared types, constants and helper functions for the trackball quadrature
// generator: speed encoding, per-axis step states, the step unit and a
// saturating adder used by the axis accumulators.
package trackball_pkg;

    // OSD speed setting as delivered on mouse_speed; codes 5..7 fall back to 100%.
    typedef enum logic [2:0] {
        SPD_100 = 3'd0,
        SPD_200 = 3'd1,
        SPD_400 = 3'd2,
        SPD_25  = 3'd3,
        SPD_50  = 3'd4
    } spd_e;

    // Per-axis step FSM states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } step_state_e;

    // One quadrature edge is worth four quarter-count units.
    localparam int STEP_UNIT = 4;

    // Joystick motion is injected once every this many step ticks.
    localparam int JOY_TICK_DIV = 8;

    // Left shift applied to a raw mouse delta for the selected speed.
    // A shift of 2 is unity gain because accumulators hold quarter counts.
    function automatic logic [2:0] speed_shift(input logic [2:0] speed);
        logic [2:0] shift_v;
        case (speed)
            SPD_100: shift_v = 3'd2;
            SPD_200: shift_v = 3'd3;
            SPD_400: shift_v = 3'd4;
            SPD_25:  shift_v = 3'd0;
            SPD_50:  shift_v = 3'd1;
            default: shift_v = 3'd2;
        endcase
        return shift_v;
    endfunction

    // a + b clamped to the symmetric range +/-(2^(w-1) - 1).
    // Callers keep operands small enough that the 32-bit sum cannot overflow.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        w
    );
        logic signed [31:0] sum_v;
        logic signed [31:0] lim_v;
        sum_v = a + b;
        lim_v = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        if (sum_v > lim_v) begin
            return lim_v;
        end else if (sum_v < -lim_v) begin
            return -lim_v;
        end else begin
            return sum_v;
        end
    endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: signed quarter-count accumulator, IDLE/STEP pacing FSM
// and the registered quadrature clock / direction outputs. Motion is only
// acted on when the shared tick strobe is high; a direction reversal costs
// one tick so that dir is stable a full tick before the next clk edge.
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int ACC_W = 14
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic                    flip,
    input  logic signed [ACC_W-1:0] add,
    output logic                    q_clk,
    output logic                    q_dir
);

    step_state_e             state_r;
    step_state_e             state_next_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [31:0]      acc_ext_s;
    logic signed [31:0]      add_ext_s;
    logic signed [31:0]      step_delta_s;
    logic signed [31:0]      sum_s;
    logic                    big_s;
    logic                    big_next_s;
    logic                    want_s;
    logic                    set_dir_s;
    logic                    consume_s;
    logic                    dir_raw_r;
    logic                    dir_raw_next_s;
    logic                    clk_r;
    logic                    clk_next_s;
    logic                    dir_out_r;

    assign acc_ext_s = {{(32-ACC_W){acc_r[ACC_W-1]}}, acc_r};
    assign add_ext_s = {{(32-ACC_W){add[ACC_W-1]}}, add};

    // Decide this tick's step action: realign direction first, otherwise emit an edge.
    always_comb begin
        want_s    = acc_r[ACC_W-1];
        big_s     = (acc_ext_s >= STEP_UNIT) || (acc_ext_s <= -STEP_UNIT);
        set_dir_s = 1'b0;
        consume_s = 1'b0;
        if (tick && big_s) begin
            if (dir_raw_r != want_s) begin
                set_dir_s = 1'b1;
            end else begin
                consume_s = 1'b1;
            end
        end else begin
            set_dir_s = 1'b0;
            consume_s = 1'b0;
        end
    end

    // Accumulator update: incoming motion plus the consumed step, saturated.
    always_comb begin
        step_delta_s = 32'sd0;
        if (consume_s) begin
            step_delta_s = want_s ? STEP_UNIT : -STEP_UNIT;
        end else begin
            step_delta_s = 32'sd0;
        end
        sum_s          = sat_add(acc_ext_s, add_ext_s + step_delta_s, ACC_W);
        acc_next_s     = sum_s[ACC_W-1:0];
        big_next_s     = (sum_s >= STEP_UNIT) || (sum_s <= -STEP_UNIT);
        dir_raw_next_s = set_dir_s ? want_s : dir_raw_r;
        clk_next_s     = consume_s ? ~clk_r : clk_r;
    end

    // Step FSM next-state: leave STEP once less than one whole step remains.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick && big_s && big_next_s) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (tick && !(big_s && big_next_s)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Step FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Accumulator, raw direction, quadrature clock and flipped direction registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r     <= {ACC_W{1'b0}};
            dir_raw_r <= 1'b0;
            clk_r     <= 1'b0;
            dir_out_r <= 1'b0;
        end else begin
            acc_r     <= acc_next_s;
            dir_raw_r <= dir_raw_next_s;
            clk_r     <= clk_next_s;
            dir_out_r <= dir_raw_next_s ^ flip;
        end
    end

    assign q_clk = clk_r;
    assign q_dir = dir_out_r;

endmodule

// File: rtl/trackball_quad_gen.sv
// PS/2 mouse to trackball quadrature converter. Detects new packets by the
// toggle bit, scales deltas by the OSD speed, and feeds two trackball_axis
// instances paced by a shared STEP_DIV tick. Y is negated so mouse-up counts
// positive. Optional joystick injection is built when TRACKBALL_JOY_EN is
// defined (adds the joy_dir port); the default build is mouse-only.
module trackball_quad_gen
    import trackball_pkg::*;
#(
    parameter int STEP_DIV = 1200,
    parameter int ACC_W    = 14
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flip,
    input  logic [2:0]  mouse_speed,
    input  logic [24:0] ps2_mouse,
`ifdef TRACKBALL_JOY_EN
    input  logic [3:0]  joy_dir,
`endif
    output logic        h_clk,
    output logic        h_dir,
    output logic        v_clk,
    output logic        v_dir
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic signed [ACC_W-1:0] ZERO_S = {ACC_W{1'b0}};
    localparam logic signed [ACC_W-1:0] UNIT_S = ACC_W'(STEP_UNIT);

    logic [CNT_W-1:0]        cnt_r;
    logic                    tick_s;
    logic                    armed_r;
    logic                    last_tog_r;
    logic                    new_pkt_s;
    logic [2:0]              shift_s;
    logic signed [ACC_W-1:0] dx_s;
    logic signed [ACC_W-1:0] dy_raw_s;
    logic signed [ACC_W-1:0] dy_s;
    logic signed [ACC_W-1:0] pkt_h_s;
    logic signed [ACC_W-1:0] pkt_v_s;
    logic signed [ACC_W-1:0] joy_h_s;
    logic signed [ACC_W-1:0] joy_v_s;
    logic signed [ACC_W-1:0] add_h_s;
    logic signed [ACC_W-1:0] add_v_s;
    logic                    ps2_unused_s;

    assign ps2_unused_s = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

    assign tick_s = (cnt_r == CNT_W'(STEP_DIV - 1));

    // Free-running step tick divider, wraps at STEP_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Toggle-bit tracking; the first cycle out of reset only learns the current level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_r    <= 1'b0;
            last_tog_r <= 1'b0;
        end else begin
            armed_r    <= 1'b1;
            last_tog_r <= ps2_mouse[24];
        end
    end

    assign new_pkt_s = armed_r && (ps2_mouse[24] != last_tog_r);

    // Extract and speed-scale the packet deltas into quarter-count units.
    always_comb begin
        shift_s  = speed_shift(mouse_speed);
        dx_s     = {{(ACC_W-9){ps2_mouse[4]}}, ps2_mouse[4], ps2_mouse[15:8]};
        dy_raw_s = {{(ACC_W-9){ps2_mouse[5]}}, ps2_mouse[5], ps2_mouse[23:16]};
        dy_s     = -dy_raw_s;
        if (new_pkt_s) begin
            pkt_h_s = dx_s <<< shift_s;
            pkt_v_s = dy_s <<< shift_s;
        end else begin
            pkt_h_s = ZERO_S;
            pkt_v_s = ZERO_S;
        end
    end

`ifdef TRACKBALL_JOY_EN
    logic [2:0] joy_div_r;
    logic       joy_tick_s;

    assign joy_tick_s = tick_s && (joy_div_r == 3'(JOY_TICK_DIV - 1));

    // Counts step ticks so joystick motion is injected every eighth one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy_div_r <= 3'd0;
        end else if (tick_s) begin
            joy_div_r <= joy_div_r + 3'd1;
        end else begin
            joy_div_r <= joy_div_r;
        end
    end

    // One step per held direction; opposing directions cancel.
    always_comb begin
        joy_h_s = ZERO_S;
        joy_v_s = ZERO_S;
        if (joy_tick_s) begin
            if (joy_dir[3] && !joy_dir[2]) begin
                joy_h_s = UNIT_S;
            end else if (joy_dir[2] && !joy_dir[3]) begin
                joy_h_s = -UNIT_S;
            end else begin
                joy_h_s = ZERO_S;
            end
            if (joy_dir[0] && !joy_dir[1]) begin
                joy_v_s = UNIT_S;
            end else if (joy_dir[1] && !joy_dir[0]) begin
                joy_v_s = -UNIT_S;
            end else begin
                joy_v_s = ZERO_S;
            end
        end else begin
            joy_h_s = ZERO_S;
            joy_v_s = ZERO_S;
        end
    end
`else
    assign joy_h_s = ZERO_S;
    assign joy_v_s = UNIT_S & ZERO_S;
`endif

    assign add_h_s = pkt_h_s + joy_h_s;
    assign add_v_s = pkt_v_s + joy_v_s;

    trackball_axis #(
        .ACC_W   (ACC_W)
    ) u_h_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s),
        .flip    (flip),
        .add     (add_h_s),
        .q_clk   (h_clk),
        .q_dir   (h_dir)
    );

    trackball_axis #(
        .ACC_W   (ACC_W)
    ) u_v_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s),
        .flip    (flip),
        .add     (add_v_s),
        .q_clk   (v_clk),
        .q_dir   (v_dir)
    );

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Scoreboard bench for trackball_quad_gen: expected quadrature edges are
// queued per axis when motion is injected and popped as edges appear.
module tb_trackball_quad_gen;

    localparam int STEP_DIV = 1200;
    localparam int ACC_W    = 14;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flip = 1'b0;
    logic [2:0]  mouse_speed = 3'd0;
    logic [24:0] ps2_mouse = 25'd0;
    logic        h_clk;
    logic        h_dir;
    logic        v_clk;
    logic        v_dir;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic tog = 1'b0;
    logic h_prev = 1'b0;
    logic v_prev = 1'b0;

    typedef struct {
        logic clk_v;
        logic dir_v;
    } edge_t;

    edge_t exp_h[$];
    edge_t exp_v[$];
    int    h_edge_cyc[$];

    always #5 clk = ~clk;

    trackball_quad_gen #(
        .STEP_DIV    (STEP_DIV),
        .ACC_W       (ACC_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flip        (flip),
        .mouse_speed (mouse_speed),
        .ps2_mouse   (ps2_mouse),
        .h_clk       (h_clk),
        .h_dir       (h_dir),
        .v_clk       (v_clk),
        .v_dir       (v_dir)
    );

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitor: every quadrature clock change must match the next queued edge.
    always @(negedge clk) begin
        edge_t e;
        if (h_clk !== h_prev) begin
            h_edge_cyc.push_back(cyc);
            if (exp_h.size() == 0) begin
                check_val("h_unexpected_edge", 1, 0);
            end else begin
                e = exp_h.pop_front();
                check_val("h_edge_clk", h_clk, e.clk_v);
                check_val("h_edge_dir", h_dir, e.dir_v);
            end
            h_prev = h_clk;
        end
        if (v_clk !== v_prev) begin
            if (exp_v.size() == 0) begin
                check_val("v_unexpected_edge", 1, 0);
            end else begin
                e = exp_v.pop_front();
                check_val("v_edge_clk", v_clk, e.clk_v);
                check_val("v_edge_dir", v_dir, e.dir_v);
            end
            v_prev = v_clk;
        end
    end

    function automatic edge_t mk(input logic c, input logic d);
        edge_t e;
        e.clk_v = c;
        e.dir_v = d;
        return e;
    endfunction

    task automatic set_ps2(input logic t, input logic [8:0] dx, input logic [8:0] dy);
        ps2_mouse        = 25'd0;
        ps2_mouse[24]    = t;
        ps2_mouse[4]     = dx[8];
        ps2_mouse[15:8]  = dx[7:0];
        ps2_mouse[5]     = dy[8];
        ps2_mouse[23:16] = dy[7:0];
    endtask

    task automatic send_pkt(input logic [8:0] dx, input logic [8:0] dy);
        @(negedge clk);
        tog = ~tog;
        set_ps2(tog, dx, dy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_h_clk", h_clk, 0);
        check_val("rst_v_clk", v_clk, 0);
        check_val("rst_h_dir", h_dir, 0);
        check_val("rst_v_dir", v_dir, 0);
        check_val("rst_acc_h", $signed(dut.u_h_axis.acc_r), 0);
        check_val("rst_acc_v", $signed(dut.u_v_axis.acc_r), 0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic sync_tick();
        int k;
        k = 0;
        while (dut.tick_s !== 1'b1 && k < 2 * STEP_DIV) begin
            @(negedge clk);
            k++;
        end
        check_val("tick_seen", dut.tick_s, 1);
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * STEP_DIV) @(negedge clk);
    endtask

    initial begin
        int n0;

        // Reset, then dx=+3 at 100%: three forward edges one tick apart.
        do_reset();
        h_edge_cyc.delete();
        sync_tick();
        send_pkt(9'd3, 9'd0);
        check_val("t1_acc", $signed(dut.u_h_axis.acc_r), 12);
        exp_h.push_back(mk(1'b1, 1'b0));
        exp_h.push_back(mk(1'b0, 1'b0));
        exp_h.push_back(mk(1'b1, 1'b0));
        wait_ticks(4);
        check_val("t1_edges", h_edge_cyc.size(), 3);
        if (h_edge_cyc.size() >= 3) begin
            check_val("t1_space1", h_edge_cyc[1] - h_edge_cyc[0], STEP_DIV);
            check_val("t1_space2", h_edge_cyc[2] - h_edge_cyc[1], STEP_DIV);
        end
        check_val("t1_acc_end", $signed(dut.u_h_axis.acc_r), 0);
        check_val("t1_hdir", h_dir, 0);
        check_val("t1_pending", exp_h.size(), 0);

        // dx=-2: first tick only turns direction, next two ticks step.
        sync_tick();
        send_pkt(9'h1FE, 9'd0);
        check_val("t2_acc", $signed(dut.u_h_axis.acc_r), -8);
        exp_h.push_back(mk(1'b0, 1'b1));
        exp_h.push_back(mk(1'b1, 1'b1));
        wait_ticks(1);
        check_val("t2_dir_turn", h_dir, 1);
        check_val("t2_no_edge", h_clk, 1);
        check_val("t2_acc_held", $signed(dut.u_h_axis.acc_r), -8);
        wait_ticks(2);
        check_val("t2_acc_end", $signed(dut.u_h_axis.acc_r), 0);
        check_val("t2_pending", exp_h.size(), 0);

        // 25%: three dx=+1 leave a sub-step fraction; a fourth makes one step.
        sync_tick();
        mouse_speed = 3'd3;
        n0 = h_edge_cyc.size();
        send_pkt(9'd1, 9'd0);
        send_pkt(9'd1, 9'd0);
        send_pkt(9'd1, 9'd0);
        wait_ticks(2);
        check_val("t3_frac", $signed(dut.u_h_axis.acc_r), 3);
        check_val("t3_no_edges", h_edge_cyc.size() - n0, 0);
        send_pkt(9'd1, 9'd0);
        check_val("t3_acc4", $signed(dut.u_h_axis.acc_r), 4);
        exp_h.push_back(mk(1'b0, 1'b0));
        wait_ticks(3);
        check_val("t3_acc_end", $signed(dut.u_h_axis.acc_r), 0);
        check_val("t3_hdir", h_dir, 0);
        check_val("t3_edges", h_edge_cyc.size() - n0, 1);

        // 400%: repeated dy=127 (upward) saturates at +8191 without wrapping.
        sync_tick();
        mouse_speed = 3'd2;
        send_pkt(9'h181, 9'h181);
        check_val("t4_first", $signed(dut.u_v_axis.acc_r), 2032);
        check_val("t4_h_first", $signed(dut.u_h_axis.acc_r), -2032);
        do_reset();
        sync_tick();
        send_pkt(9'd0, 9'h181);
        send_pkt(9'd0, 9'h181);
        send_pkt(9'd0, 9'h181);
        send_pkt(9'd0, 9'h181);
        send_pkt(9'd0, 9'h181);
        check_val("t4_sat", $signed(dut.u_v_axis.acc_r), 8191);
        exp_v.push_back(mk(1'b1, 1'b0));
        exp_v.push_back(mk(1'b0, 1'b0));
        wait_ticks(2);
        check_val("t4_drain", $signed(dut.u_v_axis.acc_r), 8183);
        send_pkt(9'd0, 9'h181);
        check_val("t4_resat", $signed(dut.u_v_axis.acc_r), 8191);
        exp_v.push_back(mk(1'b1, 1'b0));
        wait_ticks(1);
        check_val("t4_after", $signed(dut.u_v_axis.acc_r), 8187);
        check_val("t4_vdir", v_dir, 0);
        exp_v.push_back(mk(1'b0, 1'b0));
        do_reset();
        check_val("t4_pending", exp_v.size(), 0);

        // Flip mid-motion: directions invert next cycle with no extra edge.
        sync_tick();
        mouse_speed = 3'd0;
        send_pkt(9'd2, 9'h1FE);
        exp_h.push_back(mk(1'b1, 1'b0));
        exp_v.push_back(mk(1'b1, 1'b0));
        wait_ticks(1);
        repeat (100) @(negedge clk);
        flip = 1'b1;
        @(negedge clk);
        check_val("t5_hdir_flip", h_dir, 1);
        check_val("t5_vdir_flip", v_dir, 1);
        check_val("t5_hclk_same", h_clk, 1);
        check_val("t5_vclk_same", v_clk, 1);
        exp_h.push_back(mk(1'b0, 1'b1));
        exp_v.push_back(mk(1'b0, 1'b1));
        wait_ticks(2);
        check_val("t5_acc_h", $signed(dut.u_h_axis.acc_r), 0);
        check_val("t5_acc_v", $signed(dut.u_v_axis.acc_r), 0);
        check_val("t5_pending", exp_h.size() + exp_v.size(), 0);
        flip = 1'b0;
        @(negedge clk);
        check_val("t5_unflip", h_dir, 0);

        // Toggle bit high through reset release is not a packet; next toggle is one.
        tog = 1'b1;
        set_ps2(tog, 9'd5, 9'd0);
        do_reset();
        repeat (10) @(negedge clk);
        check_val("t6_no_pkt", $signed(dut.u_h_axis.acc_r), 0);
        sync_tick();
        send_pkt(9'd1, 9'd0);
        check_val("t6_one_pkt", $signed(dut.u_h_axis.acc_r), 4);
        exp_h.push_back(mk(1'b1, 1'b0));
        wait_ticks(2);
        check_val("t6_acc_end", $signed(dut.u_h_axis.acc_r), 0);
        check_val("t6_pending", exp_h.size() + exp_v.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
